// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and widths for the instruction fetch unit.
// Imported by the PC-select interface, the pc_next sub-module and the top level.
package fetch_pkg;

  localparam int ADDR_W      = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;
  localparam int CNT_W       = 4;

  typedef enum logic {
    WAIT  = 1'b0,
    VALID = 1'b1
  } fetch_state_e;

  // Redirect targets are forced onto an instruction boundary.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Next-PC selection bundle between the fetch control (master) and pc_next (slave).
// The master supplies the selection causes; the slave returns the chosen next PC.
interface pc_sel_if
  import fetch_pkg::*;
  ;
  logic              rst;
  logic              redirect;
  logic              advance;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] cur_pc;
  logic [ADDR_W-1:0] nxt_pc;

  modport master (
    output rst, redirect, advance, target, cur_pc,
    input  nxt_pc
  );

  modport slave (
    input  rst, redirect, advance, target, cur_pc,
    output nxt_pc
  );
endinterface

// File: rtl/instruction_fetch_unit_pc_next.sv
// Combinational next-PC selection: reset, then redirect, then sequential increment, else hold.
// The PC register itself lives in the top level.
module pc_next
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  pc_sel_if.slave sel
);

  always_comb begin
    sel.nxt_pc = sel.cur_pc;
    if (sel.rst) begin
      sel.nxt_pc = RESET_PC;
    end else if (sel.redirect) begin
      sel.nxt_pc = align_pc(sel.target);
    end else if (sel.advance) begin
      // Wraps modulo 2^64 by construction.
      sel.nxt_pc = sel.cur_pc + ADDR_W'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds Address for RD_WAIT_CYCLES, captures Data, and offers it
// to decode; execute can redirect the PC at any time.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC       = 64'h0,
  parameter int unsigned       RD_WAIT_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  Address,
  input  logic [INSTR_W-1:0] Data,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic               InstrValid,
  input  logic               InstrReady,
  input  logic               BranchTaken,
  input  logic [ADDR_W-1:0]  BranchTarget,
  output logic [31:0]        FetchCount
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_WAIT_CYCLES - 1);

  fetch_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic [31:0]        fcnt_q, fcnt_d;
  logic               capture;

  pc_sel_if u_sel ();

  assign u_sel.rst      = Reset;
  assign u_sel.redirect = BranchTaken;
  assign u_sel.advance  = capture;
  assign u_sel.target   = BranchTarget;
  assign u_sel.cur_pc   = pc_q;
  assign pc_d           = u_sel.nxt_pc;

  pc_next #(
    .RESET_PC (RESET_PC)
  ) u_pc_next (
    .sel (u_sel)
  );

  // Handshake: InstrValid is high for the whole VALID state and Instruction/InstrPC are
  // stable while it is high; the instruction is consumed on a rising edge where
  // InstrValid and InstrReady are both 1. A redirect in that same cycle still consumes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    fcnt_d  = fcnt_q;
    capture = 1'b0;
    if (BranchTaken) begin
      state_d = WAIT;
      cnt_d   = CNT_LOAD;
    end else begin
      case (state_q)
        WAIT: begin
          if (cnt_q == '0) begin
            capture = 1'b1;
            instr_d = Data;
            ipc_d   = pc_q;
            fcnt_d  = (fcnt_q == 32'hFFFF_FFFF) ? fcnt_q : fcnt_q + 32'd1;
            state_d = VALID;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        VALID: begin
          if (InstrReady) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
        default: begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    pc_q <= pc_d;
    if (Reset) begin
      state_q <= WAIT;
      cnt_q   <= CNT_LOAD;
      instr_q <= '0;
      ipc_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign Address     = pc_q;
  assign Instruction = instr_q;
  assign InstrPC     = ipc_q;
  assign InstrValid  = (state_q == VALID);
  assign FetchCount  = fcnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: one instance with RD_WAIT_CYCLES=2 and one with
// RD_WAIT_CYCLES=1 and InstrReady tied high, each fed by an address-keyed memory model.
module tb_instruction_fetch_unit;

  logic        clk;
  int          n_compared;
  int          n_mismatched;

  // RD_WAIT_CYCLES = 2 instance
  logic        rst;
  logic [63:0] address;
  logic [31:0] data;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [31:0] fetch_count;

  // RD_WAIT_CYCLES = 1 instance
  logic        rst1;
  logic [63:0] address1;
  logic [31:0] data1;
  logic [31:0] instr1;
  logic [63:0] instr_pc1;
  logic        instr_valid1;
  logic        branch_taken1;
  logic [63:0] branch_target1;
  logic [31:0] fetch_count1;

  function automatic logic [31:0] mem_word(input logic [63:0] addr);
    case (addr)
      64'h0:   return 32'hF840_03E9;
      64'h1C:  return 32'hB400_008C;
      default: return addr[31:0] ^ 32'hDEAD_0000;
    endcase
  endfunction

  always_comb data  = mem_word(address);
  always_comb data1 = mem_word(address1);

  instruction_fetch_unit #(
    .RESET_PC       (64'h0),
    .RD_WAIT_CYCLES (2)
  ) u_dut (
    .CLK          (clk),
    .Reset        (rst),
    .Address      (address),
    .Data         (data),
    .Instruction  (instr),
    .InstrPC      (instr_pc),
    .InstrValid   (instr_valid),
    .InstrReady   (instr_ready),
    .BranchTaken  (branch_taken),
    .BranchTarget (branch_target),
    .FetchCount   (fetch_count)
  );

  instruction_fetch_unit #(
    .RESET_PC       (64'h0),
    .RD_WAIT_CYCLES (1)
  ) u_dut1 (
    .CLK          (clk),
    .Reset        (rst1),
    .Address      (address1),
    .Data         (data1),
    .Instruction  (instr1),
    .InstrPC      (instr_pc1),
    .InstrValid   (instr_valid1),
    .InstrReady   (1'b1),
    .BranchTaken  (branch_taken1),
    .BranchTarget (branch_target1),
    .FetchCount   (fetch_count1)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid_pc(input logic [63:0] pc, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (instr_valid && instr_pc == pc) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check_eq("reach_pc", 64'(found), 64'd1);
  endtask

  initial begin
    n_compared     = 0;
    n_mismatched   = 0;
    rst            = 1'b1;
    instr_ready    = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = '0;
    rst1           = 1'b1;
    branch_taken1  = 1'b0;
    branch_target1 = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_valid", 64'(instr_valid), 64'd0);
    check_eq("rst_addr",  address,          64'h0);
    check_eq("rst_instr", 64'(instr),       64'h0);
    check_eq("rst_ipc",   instr_pc,         64'h0);
    check_eq("rst_fcnt",  64'(fetch_count), 64'd0);

    // First fetch: capture two edges after release
    rst = 1'b0;
    step();
    check_eq("wait1_valid", 64'(instr_valid), 64'd0);
    step();
    check_eq("cap0_valid", 64'(instr_valid), 64'd1);
    check_eq("cap0_instr", 64'(instr),       64'hF840_03E9);
    check_eq("cap0_ipc",   instr_pc,         64'h0);
    check_eq("cap0_addr",  address,          64'h4);
    check_eq("cap0_fcnt",  64'(fetch_count), 64'd1);

    // Stall in VALID
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stall_valid", 64'(instr_valid), 64'd1);
      check_eq("stall_instr", 64'(instr),       64'hF840_03E9);
      check_eq("stall_ipc",   instr_pc,         64'h0);
      check_eq("stall_addr",  address,          64'h4);
      check_eq("stall_fcnt",  64'(fetch_count), 64'd1);
    end
    instr_ready = 1'b1;
    step();
    check_eq("hs_valid", 64'(instr_valid), 64'd0);
    check_eq("hs_addr",  address,          64'h4);

    // Stream up to PC 0x28, then redirect to 0x1C while consuming it
    wait_valid_pc(64'h28, 200);
    check_eq("pre_br_fcnt", 64'(fetch_count), 64'd11);
    branch_taken  = 1'b1;
    branch_target = 64'h1C;
    step();
    branch_taken = 1'b0;
    instr_ready  = 1'b0;
    check_eq("br_addr",  address,          64'h1C);
    check_eq("br_valid", 64'(instr_valid), 64'd0);
    check_eq("br_fcnt",  64'(fetch_count), 64'd11);
    step();
    step();
    check_eq("br_cap_valid", 64'(instr_valid), 64'd1);
    check_eq("br_cap_instr", 64'(instr),       64'hB400_008C);
    check_eq("br_cap_ipc",   instr_pc,         64'h1C);
    check_eq("br_cap_addr",  address,          64'h20);
    check_eq("br_cap_fcnt",  64'(fetch_count), 64'd12);

    // Unaligned redirect landing on the capture cycle
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check_eq("w20_valid", 64'(instr_valid), 64'd0);
    check_eq("w20_addr",  address,          64'h20);
    step();
    branch_taken  = 1'b1;
    branch_target = 64'h1F;
    step();
    branch_taken = 1'b0;
    check_eq("una_addr",  address,          64'h1C);
    check_eq("una_valid", 64'(instr_valid), 64'd0);
    check_eq("una_fcnt",  64'(fetch_count), 64'd12);
    check_eq("una_instr", 64'(instr),       64'hB400_008C);
    step();
    step();
    check_eq("una_cap_valid", 64'(instr_valid), 64'd1);
    check_eq("una_cap_ipc",   instr_pc,         64'h1C);
    check_eq("una_cap_fcnt",  64'(fetch_count), 64'd13);

    // Reset mid-WAIT at 0x14, also overriding a redirect and ready
    branch_taken  = 1'b1;
    branch_target = 64'h14;
    instr_ready   = 1'b1;
    step();
    branch_taken = 1'b0;
    instr_ready  = 1'b0;
    check_eq("w14_addr",  address,          64'h14);
    check_eq("w14_valid", 64'(instr_valid), 64'd0);
    check_eq("w14_fcnt",  64'(fetch_count), 64'd13);
    step();
    rst           = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 64'h40;
    instr_ready   = 1'b1;
    step();
    rst          = 1'b0;
    branch_taken = 1'b0;
    instr_ready  = 1'b0;
    check_eq("mrst_addr",  address,          64'h0);
    check_eq("mrst_valid", 64'(instr_valid), 64'd0);
    check_eq("mrst_fcnt",  64'(fetch_count), 64'd0);
    check_eq("mrst_instr", 64'(instr),       64'h0);
    step();
    check_eq("mrst_wait_valid", 64'(instr_valid), 64'd0);
    step();
    check_eq("resume_valid", 64'(instr_valid), 64'd1);
    check_eq("resume_instr", 64'(instr),       64'hF840_03E9);
    check_eq("resume_ipc",   instr_pc,         64'h0);
    check_eq("resume_fcnt",  64'(fetch_count), 64'd1);

    // RD_WAIT_CYCLES=1 instance: alternating valid, then wrap at the top of memory
    rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("r1_valid_hi", 64'(instr_valid1), 64'd1);
      check_eq("r1_ipc",      instr_pc1,         64'(4 * i));
      check_eq("r1_addr_hi",  address1,          64'(4 * (i + 1)));
      step();
      check_eq("r1_valid_lo", 64'(instr_valid1), 64'd0);
      check_eq("r1_addr_lo",  address1,          64'(4 * (i + 1)));
    end
    branch_taken1  = 1'b1;
    branch_target1 = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    branch_taken1 = 1'b0;
    check_eq("r1_top_addr",  address1,          64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("r1_top_valid", 64'(instr_valid1), 64'd0);
    check_eq("r1_top_fcnt",  64'(fetch_count1), 64'd4);
    step();
    check_eq("r1_wrap_valid", 64'(instr_valid1), 64'd1);
    check_eq("r1_wrap_ipc",   instr_pc1,         64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("r1_wrap_instr", 64'(instr1),       64'(mem_word(64'hFFFF_FFFF_FFFF_FFFC)));
    check_eq("r1_wrap_addr",  address1,          64'h0);
    check_eq("r1_wrap_fcnt",  64'(fetch_count1), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
